// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush for load-use, divide occupancy and
// taken jumps, plus a saturating stall-cycle counter and a sticky protocol-error flag.
module pipe_hazard_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned RADDR_WIDTH = 5,
    parameter int unsigned DIV_CYCLES  = 33,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   id_reg1_re_i,
    input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
    input  logic                   id_reg2_re_i,
    input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
    input  logic                   exe_is_load_i,
    input  logic                   exe_reg_we_i,
    input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
    input  logic                   div_start_i,
    input  logic                   div_done_i,
    input  logic                   jump_req_i,
    input  logic [ADDR_WIDTH-1:0]  jump_addr_i,
    output logic [4:0]             stall_o,
    output logic [4:0]             flush_o,
    output logic                   jump_o,
    output logic [ADDR_WIDTH-1:0]  jump_addr_o,
    output logic                   busy_o,
    output logic [CNT_WIDTH-1:0]   stall_cnt_o,
    output logic                   err_o
);

    localparam int unsigned DivCntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic {
        StRun,
        StDivWait
    } state_e;

    state_e               r_state, w_state_next;
    logic [DivCntW-1:0]   r_div_cnt, w_div_cnt_next;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 r_err;
    logic                 w_err_set;
    logic                 w_load_use;
    logic [4:0]           w_stall, w_flush;
    logic                 w_jump, w_busy;

    // x0 is hardwired zero, so a load targeting it can never create a real dependency.
    assign w_load_use = exe_is_load_i && exe_reg_we_i && (exe_reg_waddr_i != '0) &&
                        ((id_reg1_re_i && (id_reg1_raddr_i == exe_reg_waddr_i)) ||
                         (id_reg2_re_i && (id_reg2_raddr_i == exe_reg_waddr_i)));

    always_comb begin
        w_state_next   = r_state;
        w_div_cnt_next = r_div_cnt;
        w_err_set      = 1'b0;
        w_stall        = 5'b00000;
        w_flush        = 5'b00000;
        w_jump         = 1'b0;
        w_busy         = 1'b0;
        unique case (r_state)
            StRun: begin
                if (jump_req_i) begin
                    w_jump  = 1'b1;
                    w_flush = 5'b00110;
                    w_err_set = div_start_i;
                end else if (div_start_i) begin
                    w_stall        = 5'b01111;
                    w_flush        = 5'b10000;
                    w_state_next   = StDivWait;
                    w_div_cnt_next = DivCntW'(DIV_CYCLES - 1);
                end else if (w_load_use) begin
                    w_stall = 5'b00011;
                    w_flush = 5'b00100;
                end
                if (div_done_i) begin
                    w_err_set = 1'b1;
                end
            end
            StDivWait: begin
                w_stall = 5'b01111;
                w_flush = 5'b10000;
                w_busy  = 1'b1;
                if (div_done_i) begin
                    w_state_next = StRun;
                end else if (r_div_cnt == '0) begin
                    w_err_set    = 1'b1;
                    w_state_next = StRun;
                end else begin
                    w_div_cnt_next = r_div_cnt - 1'b1;
                end
            end
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= StRun;
            r_div_cnt   <= '0;
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_div_cnt_next;
            if (w_stall[0] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Control outputs are forced quiet while reset is held, regardless of inputs.
    assign stall_o     = rst_n_i ? w_stall : 5'b00000;
    assign flush_o     = rst_n_i ? w_flush : 5'b00000;
    assign jump_o      = rst_n_i & w_jump;
    assign jump_addr_o = (rst_n_i && w_jump) ? jump_addr_i : '0;
    assign busy_o      = rst_n_i & w_busy;
    assign stall_cnt_o = r_stall_cnt;
    assign err_o       = r_err;

endmodule
